// File: rtl/reg_file_alu_ctrl.sv
// rtl/reg_file_alu_ctrl.sv - multi-cycle fetch/decode/exec sequencer driving the reg_file_alu datapath
module reg_file_alu_ctrl #(
   parameter int PC_W = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   output logic [PC_W-1:0] imem_addr,
   input  logic [19:0]     imem_data,
   input  logic            Zero,
   output logic [3:0]      RA1,
   output logic [3:0]      RA2,
   output logic [3:0]      WA,
   output logic [7:0]      immediate,
   output logic [1:0]      ALUControl,
   output logic            ALUSrc,
   output logic            write_enable,
   output logic            busy,
   output logic            done,
   output logic            illegal,
   output logic [PC_W-1:0] pc
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_HALT
   } state_t;

   state_t          state, state_nxt;
   logic [19:0]     ir;
   logic            z_flag, z_flag_nxt;
   logic            illegal_nxt;
   logic [PC_W-1:0] pc_nxt;
   logic            load_ir;
   logic [3:0]      opcode;
   logic            is_alu_op;
   logic            is_illegal;

   assign opcode     = ir[19:16];
   assign is_alu_op  = (opcode[3:2] == 2'b01) || (opcode[3:2] == 2'b10);
   assign is_illegal = (opcode inside {4'h1, 4'h2, 4'h3, 4'hE});

   assign RA1        = ir[11:8];
   assign RA2        = ir[3:0];
   assign WA         = ir[15:12];
   assign immediate  = ir[7:0];
   assign ALUControl = ir[17:16];
   assign ALUSrc     = (opcode[3:2] == 2'b10);
   assign imem_addr  = pc;

   // Gated by rst_n so a reset edge landing in EXEC never commits a write.
   assign write_enable = (state == S_EXEC) & is_alu_op & rst_n;
   assign busy         = (state == S_FETCH) | (state == S_DECODE) | (state == S_EXEC);
   assign done         = (state == S_HALT);

   always_comb begin
      state_nxt   = state;
      pc_nxt      = pc;
      illegal_nxt = illegal;
      z_flag_nxt  = z_flag;
      load_ir     = 1'b0;
      case (state)
         S_IDLE, S_HALT: begin
            if (start) begin
               pc_nxt      = '0;
               illegal_nxt = 1'b0;
               z_flag_nxt  = 1'b0;
               state_nxt   = S_FETCH;
            end
         end
         S_FETCH: state_nxt = S_DECODE;
         S_DECODE: begin
            load_ir   = 1'b1;
            state_nxt = S_EXEC;
         end
         S_EXEC: begin
            state_nxt = S_FETCH;
            case (opcode)
               4'hC:    pc_nxt = z_flag ? ir[PC_W-1:0] : pc + 1'b1;
               4'hD:    pc_nxt = ir[PC_W-1:0];
               4'hF:    state_nxt = S_HALT;
               default: pc_nxt = pc + 1'b1;
            endcase
            if (is_alu_op)  z_flag_nxt  = Zero;
            if (is_illegal) illegal_nxt = 1'b1;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         ir      <= '0;
         pc      <= '0;
         z_flag  <= 1'b0;
         illegal <= 1'b0;
      end else begin
         state   <= state_nxt;
         pc      <= pc_nxt;
         z_flag  <= z_flag_nxt;
         illegal <= illegal_nxt;
         if (load_ir) ir <= imem_data;
      end
   end

endmodule

// File: tb/tb_reg_file_alu_ctrl.sv
// tb/tb_reg_file_alu_ctrl.sv - directed bench for reg_file_alu_ctrl
module tb_reg_file_alu_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic [7:0] imem_addr;
   logic [19:0] imem_data;
   logic       Zero;
   logic [3:0] RA1, RA2, WA;
   logic [7:0] immediate;
   logic [1:0] ALUControl;
   logic       ALUSrc, write_enable, busy, done, illegal;
   logic [7:0] pc;

   logic [19:0] mem [256];
   int checks = 0;
   int errors = 0;

   reg_file_alu_ctrl #(.PC_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .imem_addr(imem_addr), .imem_data(imem_data), .Zero(Zero),
      .RA1(RA1), .RA2(RA2), .WA(WA), .immediate(immediate),
      .ALUControl(ALUControl), .ALUSrc(ALUSrc), .write_enable(write_enable),
      .busy(busy), .done(done), .illegal(illegal), .pc(pc)
   );

   always #5 clk = ~clk;

   always @(posedge clk) imem_data <= mem[imem_addr];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Pulse start for one edge; returns at the negedge of cycle 1 (FETCH).
   task automatic go();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 20'h0;
      rst_n = 1'b0;
      start = 1'b1;
      Zero  = 1'b0;

      // Reset held with start high
      cyc(2);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_pc", 32'(pc), 32'h0);
      chk("rst_addr", 32'(imem_addr), 32'h0);
      chk("rst_we", 32'(write_enable), 32'h0);
      chk("rst_illegal", 32'(illegal), 32'h0);
      chk("rst_fields", {WA, RA1, RA2, immediate, ALUControl, ALUSrc}, 32'h0);
      rst_n = 1'b1;
      start = 1'b0;
      cyc(1);
      chk("idle_busy", 32'(busy), 32'h0);

      // Immediate op then halt
      mem[0] = 20'hA100A;
      mem[1] = 20'hF0000;
      go();
      chk("imm_c1_busy", 32'(busy), 32'h1);
      chk("imm_c1_addr", 32'(imem_addr), 32'h0);
      cyc(1);
      chk("imm_c2_we", 32'(write_enable), 32'h0);
      cyc(1);
      chk("imm_c3_WA", 32'(WA), 32'h1);
      chk("imm_c3_RA1", 32'(RA1), 32'h0);
      chk("imm_c3_RA2", 32'(RA2), 32'hA);
      chk("imm_c3_imm", 32'(immediate), 32'h0A);
      chk("imm_c3_src", 32'(ALUSrc), 32'h1);
      chk("imm_c3_ctl", 32'(ALUControl), 32'h2);
      chk("imm_c3_we", 32'(write_enable), 32'h1);
      cyc(1);
      chk("imm_c4_we", 32'(write_enable), 32'h0);
      chk("imm_c4_addr", 32'(imem_addr), 32'h1);
      cyc(2);
      chk("imm_c6_we", 32'(write_enable), 32'h0);
      chk("imm_c6_done", 32'(done), 32'h0);
      cyc(1);
      chk("imm_c7_done", 32'(done), 32'h1);
      chk("imm_c7_busy", 32'(busy), 32'h0);
      chk("imm_c7_pc", 32'(pc), 32'h1);
      cyc(1);
      chk("imm_c8_done", 32'(done), 32'h1);

      // Branch taken
      mem[0] = 20'h40001;
      mem[1] = 20'hC0005;
      mem[2] = 20'hF0000;
      mem[5] = 20'hF0000;
      Zero = 1'b1;
      go();
      cyc(2);
      chk("bz_c3_we", 32'(write_enable), 32'h1);
      chk("bz_c3_src", 32'(ALUSrc), 32'h0);
      chk("bz_c3_RA2", 32'(RA2), 32'h1);
      cyc(3);
      chk("bz_c6_we", 32'(write_enable), 32'h0);
      cyc(1);
      chk("bz_taken_addr", 32'(imem_addr), 32'h05);
      chk("bz_taken_busy", 32'(busy), 32'h1);
      cyc(3);
      chk("bz_taken_done", 32'(done), 32'h1);
      chk("bz_taken_pc", 32'(pc), 32'h05);

      // Branch not taken
      Zero = 1'b0;
      go();
      cyc(6);
      chk("bz_not_addr", 32'(imem_addr), 32'h02);
      cyc(3);
      chk("bz_not_done", 32'(done), 32'h1);
      chk("bz_not_pc", 32'(pc), 32'h02);

      // Illegal opcode
      mem[0] = 20'h21234;
      mem[1] = 20'hF0000;
      go();
      cyc(2);
      chk("ill_c3_we", 32'(write_enable), 32'h0);
      chk("ill_c3_flag", 32'(illegal), 32'h0);
      cyc(1);
      chk("ill_c4_flag", 32'(illegal), 32'h1);
      chk("ill_c4_addr", 32'(imem_addr), 32'h1);
      cyc(3);
      chk("ill_halt_done", 32'(done), 32'h1);
      chk("ill_halt_flag", 32'(illegal), 32'h1);

      // Restart clears illegal; then reset lands in EXEC of 0x8300F
      mem[0] = 20'h8300F;
      go();
      chk("ill_clear", 32'(illegal), 32'h0);
      cyc(2);
      chk("rx_c3_we", 32'(write_enable), 32'h1);
      chk("rx_c3_WA", 32'(WA), 32'h3);
      rst_n = 1'b0;
      #1;
      chk("rx_gated_we", 32'(write_enable), 32'h0);
      cyc(1);
      chk("rx_busy", 32'(busy), 32'h0);
      chk("rx_done", 32'(done), 32'h0);
      chk("rx_pc", 32'(pc), 32'h0);
      chk("rx_WA", 32'(WA), 32'h0);
      rst_n = 1'b1;
      cyc(1);

      // PC wrap and start ignored while busy
      mem[0]   = 20'hD00FF;
      mem[255] = 20'h00000;
      go();
      cyc(3);
      chk("wrap_c4_addr", 32'(imem_addr), 32'hFF);
      mem[0] = 20'hF0000;
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      chk("busy_start_pc", 32'(pc), 32'hFF);
      chk("busy_start_busy", 32'(busy), 32'h1);
      cyc(2);
      chk("wrap_addr", 32'(imem_addr), 32'h00);
      cyc(3);
      chk("wrap_done", 32'(done), 32'h1);
      chk("wrap_pc", 32'(pc), 32'h00);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
